// File: rtl/cpu.sv
// 8-bit accumulator CPU with ADD/LDA/STA/JMP over a shared 64-word memory.
// Two cycles per instruction: FETCH then EXECUTE.
module cpu (
  input  logic       clk,
  input  logic       reset,
  output logic [5:0] adr_bus,
  output logic       rd_mem,
  output logic       wr_mem,
  input  logic [7:0] data_bus_in,
  output logic [7:0] data_bus_out
);

  typedef enum logic {
    FETCH   = 1'b0,
    EXECUTE = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_LDA = 2'b01,
    OP_STA = 2'b10,
    OP_JMP = 2'b11
  } op_e;

  state_e     state_q;
  logic [5:0] pc_q;
  logic [7:0] ac_q;
  logic [7:0] ir_q;

  op_e        op;
  logic [5:0] opnd;

  assign op   = op_e'(ir_q[7:6]);
  assign opnd = ir_q[5:0];

  // Strobes are gated by reset so an aborted STA never writes.
  always_comb begin
    adr_bus      = 6'd0;
    rd_mem       = 1'b0;
    wr_mem       = 1'b0;
    data_bus_out = 8'd0;
    if (!reset) begin
      if (state_q == FETCH) begin
        adr_bus = pc_q;
        rd_mem  = 1'b1;
      end else begin
        adr_bus = opnd;
        unique case (op)
          OP_ADD,
          OP_LDA: rd_mem = 1'b1;
          OP_STA: begin
            wr_mem       = 1'b1;
            data_bus_out = ac_q;
          end
          OP_JMP: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= 6'd0;
      ac_q    <= 8'd0;
      ir_q    <= 8'd0;
    end else if (state_q == FETCH) begin
      ir_q    <= data_bus_in;
      pc_q    <= pc_q + 6'd1;
      state_q <= EXECUTE;
    end else begin
      state_q <= FETCH;
      unique case (op)
        OP_ADD: ac_q <= ac_q + data_bus_in;
        OP_LDA: ac_q <= data_bus_in;
        OP_STA: ;
        OP_JMP: pc_q <= opnd;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu.sv
// Bench for cpu: instruction-level model predicts every bus cycle,
// plus hand-computed checks on memory contents and the bus trace.
module tb_cpu;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] adr_bus;
  logic       rd_mem;
  logic       wr_mem;
  logic [7:0] data_bus_out;
  wire  [7:0] data_bus_in;

  logic [7:0] mem [64];
  logic [7:0] mm  [64];

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [5:0] adr;
    logic [7:0] dout;
  } bus_t;

  bus_t       q[$];
  bus_t       tr[64];
  int         cyc;
  int         wr_cnt;
  logic [5:0] m_pc;
  logic [7:0] m_ac;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign data_bus_in = rd_mem ? mem[adr_bus] : 8'hzz;

  always @(posedge clk)
    if (wr_mem) mem[adr_bus] <= data_bus_out;

  cpu dut (
    .clk         (clk),
    .reset       (reset),
    .adr_bus     (adr_bus),
    .rd_mem      (rd_mem),
    .wr_mem      (wr_mem),
    .data_bus_in (data_bus_in),
    .data_bus_out(data_bus_out)
  );

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One whole instruction at a time, from the model's own memory copy.
  task automatic gen();
    logic [7:0] ir;
    logic [5:0] a;
    ir = mm[m_pc];
    a  = ir[5:0];
    q.push_back('{1'b1, 1'b0, m_pc, 8'd0});
    m_pc = m_pc + 6'd1;
    case (ir[7:6])
      2'd0: begin
        q.push_back('{1'b1, 1'b0, a, 8'd0});
        m_ac = m_ac + mm[a];
      end
      2'd1: begin
        q.push_back('{1'b1, 1'b0, a, 8'd0});
        m_ac = mm[a];
      end
      2'd2: q.push_back('{1'b0, 1'b1, a, m_ac});
      default: begin
        q.push_back('{1'b0, 1'b0, a, 8'd0});
        m_pc = a;
      end
    endcase
  endtask

  always @(negedge clk) begin
    bus_t act, e;
    act = '{rd_mem, wr_mem, adr_bus, data_bus_out};
    if (reset) begin
      chk("reset_bus", act, 16'h0000);
      q.delete();
      m_pc = 6'd0;
      m_ac = 8'd0;
      cyc  = 0;
    end else begin
      if (q.size() == 0) gen();
      e = q.pop_front();
      chk("bus", act, e);
      if (cyc < 64) tr[cyc] = act;
      cyc++;
      if (e.wr) mm[e.adr] = e.dout;
    end
    if (wr_mem) wr_cnt++;
  end

  task automatic put(input int a, input logic [7:0] v);
    mem[a] = v;
    mm[a]  = v;
  endtask

  task automatic clear();
    for (int i = 0; i < 64; i++) put(i, 8'h00);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    reset = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    wr_cnt = 0;
    cyc = 0;
    for (int i = 0; i < 64; i++) put(i, 8'($urandom));

    // reset with random memory
    repeat (2) @(posedge clk);
    #1;
    run(1);
    chk("first_fetch", tr[0], 16'h8000);

    // basic program
    do_reset(2);
    clear();
    put(8'h00, 8'h4A);
    put(8'h01, 8'h0A);
    put(8'h02, 8'h8B);
    put(8'h03, 8'hC3);
    put(8'h0A, 8'h08);
    run(20);
    chk("basic_cyc6", tr[5], {1'b0, 1'b1, 6'h0B, 8'h10});
    chk("basic_cyc19", tr[18], {1'b1, 1'b0, 6'h03, 8'h00});
    chk("basic_cyc20", tr[19], {1'b0, 1'b0, 6'h03, 8'h00});
    chk("basic_mem0B", {8'h0, mem[8'h0B]}, 16'h0010);

    // add overflow
    do_reset(1);
    wr_cnt = 0;
    clear();
    put(8'h00, 8'h50);
    put(8'h01, 8'h11);
    put(8'h02, 8'h92);
    put(8'h03, 8'hC3);
    put(8'h10, 8'hF0);
    put(8'h11, 8'h20);
    run(16);
    chk("ovf_mem12", {8'h0, mem[8'h12]}, 16'h0010);
    chk("ovf_writes", 16'(wr_cnt), 16'd1);

    // jump to 3F then wrap
    do_reset(1);
    clear();
    put(8'h00, 8'hFF);
    put(8'h3F, 8'h45);
    put(8'h05, 8'h77);
    run(12);
    chk("jmp_fetch3F", tr[2], {1'b1, 1'b0, 6'h3F, 8'h00});
    chk("jmp_lda05", tr[3], {1'b1, 1'b0, 6'h05, 8'h00});
    chk("jmp_wrap00", tr[4], {1'b1, 1'b0, 6'h00, 8'h00});

    // self-modifying code
    do_reset(1);
    clear();
    put(8'h00, 8'h48);
    put(8'h01, 8'h85);
    put(8'h02, 8'hC5);
    put(8'h08, 8'hC5);
    run(14);
    chk("smc_sta", tr[3], {1'b0, 1'b1, 6'h05, 8'hC5});
    chk("smc_fetch05", tr[6], {1'b1, 1'b0, 6'h05, 8'h00});
    chk("smc_exec", tr[7], {1'b0, 1'b0, 6'h05, 8'h00});
    chk("smc_mem05", {8'h0, mem[8'h05]}, 16'h00C5);

    // reset during STA execute
    do_reset(1);
    clear();
    put(8'h00, 8'h48);
    put(8'h01, 8'h89);
    put(8'h02, 8'hC2);
    put(8'h08, 8'h33);
    run(3);
    wr_cnt = 0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_writes", 16'(wr_cnt), 16'd0);
    chk("abort_mem09", {8'h0, mem[8'h09]}, 16'h0000);
    clear();
    put(8'h00, 8'h8A);
    put(8'h01, 8'hC1);
    put(8'h0A, 8'h55);
    run(8);
    chk("resume_fetch", tr[0], 16'h8000);
    chk("resume_ac0", tr[1], {1'b0, 1'b1, 6'h0A, 8'h00});
    chk("resume_mem0A", {8'h0, mem[8'h0A]}, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
